// File: rtl/glitch_free_clk_mux.sv
// Break-before-make glitch-free mux between clk_i and clk_i/DIV.
// Define CLK_MUX_STATUS_EN to add active_o = {en1, en0}.
`timescale 1ns/1ps
module glitch_free_clk_mux #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV         = 4
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       sel_i,
  output logic       clk_o
`ifdef CLK_MUX_STATUS_EN
  ,
  output logic [1:0] active_o
`endif
);
  localparam int HALF = DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

  logic [CW-1:0]          cnt;
  logic                   clk_div;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sel_s;
  logic                   en0, en1;
  logic                   en0_d, en1_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      clk_div <= ~clk_div;
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sel_i};
  end

  assign sel_s = sync_pipe[SYNC_STAGES-1];

  // en1 may only move while clk_div is low; clk_div is stable at negedge.
  always_comb begin
    en0_d = ~sel_s & ~en1;
    en1_d = en1;
    if (!clk_div) en1_d = sel_s & ~en0;
  end

  always_ff @(negedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      en0 <= 1'b0;
      en1 <= 1'b0;
    end else begin
      en0 <= en0_d;
      en1 <= en1_d;
    end
  end

  assign clk_o = (clk_i & en0) | (clk_div & en1);

`ifdef CLK_MUX_STATUS_EN
  assign active_o = {en1, en0};
`endif

endmodule

// File: tb/tb_glitch_free_clk_mux.sv
// Directed bench for glitch_free_clk_mux (DIV=4, SYNC_STAGES=2, 10 ns clk_i).
`timescale 1ns/1ps
module tb_glitch_free_clk_mux;
  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  logic sel_i  = 1'b0;
  logic clk_o;
`ifdef CLK_MUX_STATUS_EN
  logic [1:0] active_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int pcnt  = 0;
  int runt_cnt = 0;
  realtime runt_len  = 0.0;
  realtime last_edge = 0.0;
  realtime last_rst  = 0.0;

  glitch_free_clk_mux #(.SYNC_STAGES(2), .DIV(4)) dut (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .sel_i (sel_i),
    .clk_o (clk_o)
`ifdef CLK_MUX_STATUS_EN
    ,
    .active_o(active_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // posedges since reset release; divided clock is high when bit 1 is set
  always @(posedge clk_i or posedge arst_i)
    if (arst_i) pcnt <= 0;
    else        pcnt <= pcnt + 1;

  // phase-width recorder; phases touching a reset are exempt
  always @(arst_i) last_rst = $realtime;
  always @(clk_o) begin
    if (!arst_i && last_edge > last_rst && ($realtime - last_edge) < 5.0) begin
      runt_cnt++;
      runt_len = $realtime - last_edge;
    end
    last_edge = $realtime;
  end

  task automatic at_pos();
    @(posedge clk_i); #2;
  endtask

  task automatic at_neg();
    @(negedge clk_i); #2;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    arst_i = 1'b1;
    sel_i  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_pos();
      n_cmp++;
      if (clk_o !== 1'b0) begin
        n_bad++; $display("FAIL rst_hold[%0d]: clk_o=%b expected 0", i, clk_o);
      end
    end
`ifdef CLK_MUX_STATUS_EN
    n_cmp++;
    if (active_o !== 2'b00) begin
      n_bad++; $display("FAIL rst_active: active_o=%b expected 00", active_o);
    end
`endif
    @(negedge clk_i); #2;
    arst_i = 1'b0;
    exp = 10'b0010101010;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) at_pos(); else at_neg();
      n_cmp++;
      if (clk_o !== exp[9-i]) begin
        n_bad++; $display("FAIL rst_release[%0d]: clk_o=%b expected %b", i, clk_o, exp[9-i]);
      end
    end
`ifdef CLK_MUX_STATUS_EN
    n_cmp++;
    if (active_o !== 2'b01) begin
      n_bad++; $display("FAIL rel_active: active_o=%b expected 01", active_o);
    end
`endif
  endtask

  task automatic test_switch_0to1();
    logic [5:0] exp;
    logic e;
    int r0;
    r0 = runt_cnt;
    sel_i = 1'b1;
    exp = 6'b101000;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) at_pos(); else at_neg();
      n_cmp++;
      if (clk_o !== exp[5-i]) begin
        n_bad++; $display("FAIL sw01_gap[%0d]: clk_o=%b expected %b", i, clk_o, exp[5-i]);
      end
    end
    repeat (4) at_pos();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) at_pos(); else at_neg();
      e = pcnt[1];
      n_cmp++;
      if (clk_o !== e) begin
        n_bad++; $display("FAIL sw01_div[%0d]: clk_o=%b expected %b", i, clk_o, e);
      end
    end
    n_cmp++;
    if (runt_cnt !== r0) begin
      n_bad++; $display("FAIL sw01_runt: runts=%0d expected %0d (last %0t)", runt_cnt, r0, runt_len);
    end
  endtask

  task automatic test_switch_1to0();
    logic [13:0] exp;
    int k, r0;
    r0 = runt_cnt;
    k = 0;
    at_pos();
    while (pcnt % 4 != 2 && k < 8) begin at_pos(); k++; end
    n_cmp++;
    if (pcnt % 4 != 2 || clk_o !== 1'b1) begin
      n_bad++; $display("FAIL sw10_start: clk_o=%b pcnt=%0d expected high phase", clk_o, pcnt);
    end
    sel_i = 1'b0;
    exp = 14'b11100001010101;
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) at_neg(); else at_pos();
      n_cmp++;
      if (clk_o !== exp[13-i]) begin
        n_bad++; $display("FAIL sw10_seq[%0d]: clk_o=%b expected %b", i, clk_o, exp[13-i]);
      end
    end
    n_cmp++;
    if (runt_cnt !== r0) begin
      n_bad++; $display("FAIL sw10_runt: runts=%0d expected %0d (last %0t)", runt_cnt, r0, runt_len);
    end
  endtask

  task automatic test_short_pulse();
    logic [7:0] exp;
    int r0;
    r0 = runt_cnt;
    at_neg();
    #2;
    sel_i = 1'b1;
    @(posedge clk_i); #2;
    sel_i = 1'b0;
    // one posedge sees the pulse: en0 drops for exactly one clk_i period
    exp = 8'b10100010;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        if (i % 2 == 1) at_neg(); else at_pos();
      end
      n_cmp++;
      if (clk_o !== exp[7-i]) begin
        n_bad++; $display("FAIL pulse_seq[%0d]: clk_o=%b expected %b", i, clk_o, exp[7-i]);
      end
    end
    n_cmp++;
    if (runt_cnt !== r0) begin
      n_bad++; $display("FAIL pulse_runt: runts=%0d expected %0d (last %0t)", runt_cnt, r0, runt_len);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int k;
    sel_i = 1'b1;
    repeat (12) at_pos();
    k = 0;
    while (pcnt % 4 != 2 && k < 8) begin at_pos(); k++; end
    n_cmp++;
    if (pcnt % 4 != 2 || clk_o !== 1'b1) begin
      n_bad++; $display("FAIL rmid_src1: clk_o=%b pcnt=%0d expected high on divided clock", clk_o, pcnt);
    end
    #1;
    arst_i = 1'b1;
    sel_i  = 1'b0;
    #1;
    n_cmp++;
    if (clk_o !== 1'b0) begin
      n_bad++; $display("FAIL rmid_kill: clk_o=%b expected 0", clk_o);
    end
    for (int i = 0; i < 3; i++) begin
      at_pos();
      n_cmp++;
      if (clk_o !== 1'b0) begin
        n_bad++; $display("FAIL rmid_hold[%0d]: clk_o=%b expected 0", i, clk_o);
      end
    end
    @(negedge clk_i); #2;
    arst_i = 1'b0;
    exp = 8'b00101010;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) at_pos(); else at_neg();
      n_cmp++;
      if (clk_o !== exp[7-i]) begin
        n_bad++; $display("FAIL rmid_restart[%0d]: clk_o=%b expected %b", i, clk_o, exp[7-i]);
      end
    end
  endtask

  task automatic test_random();
    realtime t0;
    int s, np;
    logic e;
    t0 = $realtime;
    while ($realtime - t0 < 500000.0) begin
      s = int'($urandom_range(0, 1));
      sel_i = s[0];
      np = int'($urandom_range(10, 100));
      repeat (np - 2) @(posedge clk_i);
      at_pos();
      e = (s == 1) ? pcnt[1] : 1'b1;
      n_cmp++;
      if (clk_o !== e) begin
        n_bad++; $display("FAIL rand_pos sel=%0d: clk_o=%b expected %b at %0t", s, clk_o, e, $realtime);
      end
      at_neg();
      e = (s == 1) ? pcnt[1] : 1'b0;
      n_cmp++;
      if (clk_o !== e) begin
        n_bad++; $display("FAIL rand_neg sel=%0d: clk_o=%b expected %b at %0t", s, clk_o, e, $realtime);
      end
    end
    n_cmp++;
    if (runt_cnt !== 0) begin
      n_bad++; $display("FAIL glitch_total: runts=%0d expected 0 (last %0t ns)", runt_cnt, runt_len);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_switch_0to1();
    test_switch_1to0();
    test_short_pulse();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
